// File: rtl/fpu_fetch_controller.sv
// -----------------------------------------------------------------------------
// fpu_fetch_controller
//
// Fetches FPU instructions from a synchronous-read instruction memory. The
// memory has a one-cycle read latency and is indexed by mem_address[31:2].
// Fetched words go to decode over a valid/ready handshake.
//
// The block owns the program counter and tracks the single read in flight.
// Returned words are buffered in a 2-entry skid FIFO. A redirect (branch or
// jump) flushes the buffered words and the word in flight.
//
// Parameters
//   RESET_PC   PC loaded at reset (word aligned).
//   MEM_WORDS  instruction memory depth in words; PC wraps modulo
//              MEM_WORDS*4 (power of two).
//
// Ports
//   clock           system clock, rising edge
//   reset           asynchronous active-low reset
//   start           pulse, IDLE -> RUN
//   stop            pulse, RUN -> IDLE (FIFO still drains); wins over start
//   redirect_valid  load redirect_pc and flush
//   redirect_pc     redirect target, bits [1:0] ignored
//   mem_address     instruction memory address (the PC register)
//   machine_code    memory read data, valid the cycle after the address
//   instr_valid     FIFO head valid
//   instr_ready     decode accepts the head
//   instr_data      FIFO head instruction word
//   instr_pc        fetch address of the head word
//   busy            RUN, FIFO non-empty, or read in flight
// -----------------------------------------------------------------------------
module fpu_fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_address,
  input  logic [31:0] machine_code,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        busy
);

  localparam logic [31:0] PC_MASK = 32'(MEM_WORDS * 4) - 32'd1;
  localparam logic [31:0] PC_INIT = RESET_PC & PC_MASK & 32'hFFFF_FFFC;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        inflight;
  logic [1:0]  fifo_count;
  logic [31:0] head_data;
  logic [31:0] head_pc;
  logic [31:0] tail_data;
  logic [31:0] tail_pc;

  logic        pop;
  logic        push;
  logic        issue;
  logic [2:0]  occupancy;

  assign pop  = instr_valid && instr_ready;
  // A redirect discards the response that is arriving this cycle.
  assign push = inflight && !redirect_valid;

  // Words the FIFO will hold once this cycle's response lands and this cycle's
  // pop retires. Counting the pop as a freed slot is what allows one
  // instruction per cycle with decode always ready. The result is never
  // negative because a pop needs a non-empty FIFO.
  always_comb begin
    occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  end

  assign issue = (state == StRun) && !redirect_valid && (occupancy < 3'd2);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= StIdle;
      pc         <= PC_INIT;
      req_pc     <= 32'd0;
      inflight   <= 1'b0;
      fifo_count <= 2'd0;
      head_data  <= 32'd0;
      head_pc    <= 32'd0;
      tail_data  <= 32'd0;
      tail_pc    <= 32'd0;
    end else begin
      // Run control; stop has priority over start.
      if (stop) begin
        state <= StIdle;
      end else if (start) begin
        state <= StRun;
      end

      // Program counter.
      if (redirect_valid) begin
        pc <= redirect_pc & PC_MASK & 32'hFFFF_FFFC;
      end else if (issue) begin
        pc <= (pc + 32'd4) & PC_MASK;
      end

      inflight <= issue;
      if (issue) begin
        req_pc <= pc;
      end

      // Two-entry FIFO. The head is always in the head registers. When the
      // FIFO empties, the head registers are left alone, so instr_data and
      // instr_pc keep the last word presented.
      if (redirect_valid) begin
        // A pop in this cycle still completes; everything else is dropped.
        fifo_count <= 2'd0;
      end else begin
        unique case ({push, pop})
          2'b10: begin
            if (fifo_count == 2'd0) begin
              head_data <= machine_code;
              head_pc   <= req_pc;
            end else begin
              tail_data <= machine_code;
              tail_pc   <= req_pc;
            end
            fifo_count <= fifo_count + 2'd1;
          end
          2'b01: begin
            if (fifo_count == 2'd2) begin
              head_data <= tail_data;
              head_pc   <= tail_pc;
            end
            fifo_count <= fifo_count - 2'd1;
          end
          2'b11: begin
            if (fifo_count == 2'd2) begin
              head_data <= tail_data;
              head_pc   <= tail_pc;
              tail_data <= machine_code;
              tail_pc   <= req_pc;
            end else begin
              head_data <= machine_code;
              head_pc   <= req_pc;
            end
          end
          default: begin
            fifo_count <= fifo_count;
          end
        endcase
      end
    end
  end

  // The credit scheme must never return a word to a full FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      assert (!(push && fifo_count == 2'd2));
    end
  end

  assign mem_address = pc;
  assign instr_valid = (fifo_count != 2'd0);
  assign instr_data  = head_data;
  assign instr_pc    = head_pc;
  assign busy        = (state == StRun) || (fifo_count != 2'd0) || inflight;

endmodule
